// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug run-control block.
package dbg_pkg;

  typedef enum logic [1:0] {
    RUN,
    HALT,
    STEP
  } run_state_e;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] SEL_RST = 4'b1110;

endpackage

// File: rtl/dbg_run_ctrl_if.sv
// Debug pins, PC/memory taps and 7-segment drive for dbg_run_ctrl.
interface dbg_run_ctrl_if
  import dbg_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);

  logic                  break_en;
  logic [31:0]           breakpoint;
  logic                  one_step_en;
  logic                  one_step;
  logic [31:0]           pc_addr;
  logic                  memread_en;
  logic [ADDR_W-1:0]     out_addr;
  logic [31:0]           mem_rdata;
  logic [ADDR_W-1:0]     mem_raddr;
  logic                  run_en;
  logic                  halted;
  logic [NUM_DIGITS-1:0] sel;
  logic [7:0]            show_data;

  modport master (
    output break_en, breakpoint, one_step_en, one_step, pc_addr,
           memread_en, out_addr, mem_rdata,
    input  mem_raddr, run_en, halted, sel, show_data
  );

  modport slave (
    input  break_en, breakpoint, one_step_en, one_step, pc_addr,
           memread_en, out_addr, mem_rdata,
    output mem_raddr, run_en, halted, sel, show_data
  );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with a rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/dbg_run_ctrl.sv
// Debug run control: breakpoint/single-step gating of the pipeline and a
// scanned 4-digit display of either the PC or a peeked memory word.
module dbg_run_ctrl
  import dbg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  dbg_run_ctrl_if.slave  dbg
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  run_state_e state;
  run_state_e state_nxt;
  logic       bp_hit;
  logic       step_rise;

  logic [DIV_W-1:0]      div_cnt;
  logic [1:0]            dig;
  logic [ADDR_W-1:0]     raddr_q;
  logic                  memread_en_d;
  logic [31:0]           disp_word;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [7:0]            show_q;

  sync_edge u_step_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (dbg.one_step),
    .rise  (step_rise)
  );

  assign bp_hit = dbg.break_en && (dbg.pc_addr == dbg.breakpoint);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:  if (dbg.one_step_en || bp_hit) state_nxt = HALT;
      HALT: begin
        if (step_rise)                           state_nxt = STEP;
        else if (!dbg.one_step_en && !bp_hit)    state_nxt = RUN;
      end
      STEP: state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  // run_en is combinational so a breakpoint stalls fetch in the hit cycle.
  always_comb begin
    dbg.run_en = 1'b0;
    dbg.halted = (state == HALT);
    if (rst_n) begin
      dbg.run_en = ((state == RUN) && !bp_hit && !dbg.one_step_en) ||
                   (state == STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      dig     <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      dig     <= dig + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // sel is registered alongside show_data so the digit and its byte switch together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raddr_q      <= '0;
      memread_en_d <= 1'b0;
      disp_word    <= '0;
      sel_q        <= SEL_RST;
      show_q       <= '0;
    end else begin
      raddr_q      <= dbg.out_addr;
      memread_en_d <= dbg.memread_en;
      disp_word    <= memread_en_d ? dbg.mem_rdata : dbg.pc_addr;
      sel_q        <= ~(NUM_DIGITS'(1) << dig);
      show_q       <= disp_word[{dig, 3'b000} +: 8];
    end
  end

  assign dbg.mem_raddr = raddr_q;
  assign dbg.sel       = sel_q;
  assign dbg.show_data = show_q;

endmodule
